fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter that merges NUM_REQ producers onto one shared sync FIFO write port.
// Latency: zero; a beat is accepted and written to the FIFO in the same cycle it is offered.
// Backpressure: fifo_full deasserts every req_ready; an owner stalled by fifo_full keeps its burst.
// Optional: define FIFO_ARB_STATS_EN to add the per-requester grant_cnt counters.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [ID_WIDTH-1:0]           grant_id,
`ifdef FIFO_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0]         grant_cnt,
`endif
    output logic                          busy
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    // One extra bit lets last_grant+k be formed before the modulo wrap.
    localparam logic [ID_WIDTH:0]   NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);
    localparam logic [3:0]          BURST_W   = 4'(BURST_MAX);
    localparam logic [ID_WIDTH-1:0] LAST_RST  = ID_WIDTH'(NUM_REQ - 1);

    state_t              state;
    logic [ID_WIDTH-1:0] last_grant;
    logic [3:0]          beat_cnt;

    logic                owner_hold;
    logic                found;
    logic [ID_WIDTH-1:0] winner;
    logic [ID_WIDTH:0]   cand_w;
    logic                hs;

    // The current owner keeps the grant while it still has a beat to offer.
    assign owner_hold = (state == BURST) && req_valid[last_grant];

    // Winner select: the owner, else the first valid requester after last_grant.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand_w = '0;
        if (owner_hold) begin
            found  = 1'b1;
            winner = last_grant;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand_w = {1'b0, last_grant} + (ID_WIDTH+1)'(k);
                if (cand_w >= NUM_REQ_W) begin
                    cand_w = cand_w - NUM_REQ_W;
                end
                if (!found && req_valid[cand_w[ID_WIDTH-1:0]]) begin
                    found  = 1'b1;
                    winner = cand_w[ID_WIDTH-1:0];
                end
            end
        end
    end

    // A handshake needs a valid winner, FIFO room, and no reset in progress.
    assign hs = found && !fifo_full && !rst;

    // Output steering: one-hot ready and the winner's data, all zero without a handshake.
    always_comb begin
        req_ready = '0;
        fifo_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs && (winner == ID_WIDTH'(i))) begin
                req_ready[i] = 1'b1;
                fifo_data    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign fifo_wr_en = hs;
    assign grant_id   = hs ? winner : '0;
    assign busy       = (state == BURST) && !rst;

    // Burst FSM: start a burst on a new winner, count owner beats, drop to IDLE on completion or owner loss.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            last_grant <= LAST_RST;
        end else if (owner_hold) begin
            if (hs) begin
                beat_cnt <= beat_cnt + 4'd1;
                if ((beat_cnt + 4'd1) == BURST_W) begin
                    state <= IDLE;
                end
            end
        end else if (hs) begin
            last_grant <= winner;
            beat_cnt   <= 4'd1;
            state      <= (BURST_MAX > 1) ? BURST : IDLE;
        end else if (state == BURST) begin
            state <= IDLE;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];

    // Per-requester handshake counters, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && req_valid[i] && (cnt_q[i] != 16'hFFFF)) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign grant_cnt[g*16 +: 16] = cnt_q[g];
    end
`endif

endmodule
